spi_reg_ctrl: RTL and testbench

Register-access controller for the board's SPI slave path: oversamples the raw SPI pins (`sclk`, `cs`, `mosi`) in the system clock domain, decodes 16-bit command frames, and sequences writes and reads of a small register bank. The bank holds the LED register, so the LED bus is driven from here. The block sits between the top-level pins and the LED outputs, and it also drives `miso`.

---
 rtl/spi_reg_ctrl.sv | 112 +++++++++++
 tb/tb_spi_reg_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: oversampled SPI slave that decodes 16-bit frames into register bank reads/writes
module spi_reg_ctrl #(
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] led,
  output logic       frame_done
);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sq, cs_sq, mosi_sq;
  logic                   sclk_pq, cs_pq;
  logic [4:0]             bit_cnt_q;
  logic [6:0]             shift_q;
  logic                   wr_q;
  logic [6:0]             addr_q;
  logic [7:0]             rd_sh_q;
  logic [7:0]             led_q, scr_q, cnt_q;
  logic                   miso_q, miso_oe_q, frame_done_q;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
  logic [6:0]             cmd_addr;
  logic [7:0]             byte_in, rd_data;
  // Edge detection and read-data selection for the address being decoded
  always_comb begin
    sclk_s    = sclk_sq[SYNC_STAGES-1];
    cs_s      = cs_sq[SYNC_STAGES-1];
    mosi_s    = mosi_sq[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_pq;
    sclk_fall = ~sclk_s & sclk_pq;
    byte_in   = {shift_q, mosi_s};
    cmd_addr  = byte_in[6:0];
    rd_data   = cmd_addr == 7'd0 ? led_q :
                cmd_addr == 7'd1 ? scr_q :
                cmd_addr == 7'd2 ? cnt_q :
                cmd_addr == 7'd3 ? ID_VALUE : 8'h00;
  end
  // Synchronizers, frame FSM, register bank and registered outputs; a high cs overrides any sclk edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sq      <= '0;
      cs_sq        <= '0;
      mosi_sq      <= '0;
      sclk_pq      <= 1'b0;
      cs_pq        <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      rd_sh_q      <= '0;
      led_q        <= '0;
      scr_q        <= '0;
      cnt_q        <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sclk_sq      <= {sclk_sq[SYNC_STAGES-2:0], sclk};
      cs_sq        <= {cs_sq[SYNC_STAGES-2:0], cs};
      mosi_sq      <= {mosi_sq[SYNC_STAGES-2:0], mosi};
      sclk_pq      <= sclk_s;
      cs_pq        <= cs_s;
      miso_oe_q    <= ~cs_s;
      frame_done_q <= 1'b0;
      if (cs_s) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else begin
        if (sclk_rise) bit_cnt_q <= bit_cnt_q + 5'd1;
        case (state_q)
          IDLE: if (cs_pq) state_q <= CMD;
          CMD: if (sclk_rise) begin
            shift_q <= byte_in[6:0];
            if (bit_cnt_q == 5'd7) begin
              wr_q    <= byte_in[7];
              addr_q  <= cmd_addr;
              rd_sh_q <= rd_data;
              state_q <= DATA;
            end
          end
          DATA: if (sclk_rise) begin
            shift_q <= byte_in[6:0];
            if (bit_cnt_q == 5'd15) begin
              if (wr_q && addr_q == 7'd0) led_q <= byte_in;
              if (wr_q && addr_q == 7'd1) scr_q <= byte_in;
              cnt_q        <= cnt_q + 8'd1;
              frame_done_q <= 1'b1;
              miso_q       <= 1'b0;
              state_q      <= DONE;
            end
          end else if (sclk_fall) begin
            miso_q  <= rd_sh_q[7];
            rd_sh_q <= {rd_sh_q[6:0], 1'b0};
          end
          DONE: miso_q <= 1'b0;
        endcase
      end
    end
  end
  assign miso       = miso_q;
  assign miso_oe    = miso_oe_q;
  assign led        = led_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: table-driven SPI frame bench with a read-data scoreboard
module tb_spi_reg_ctrl;
  localparam int HP = 4;
  logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, frame_done;
  logic [7:0] led;
  int         checks = 0, failures = 0, fd_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] tx;
    int          nbits;
    logic [7:0]  rx;
    logic [7:0]  led;
    int          fd;
  } vec_t;
  vec_t v[15];

  spi_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .led(led), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [15:0] tx, input int nbits, input bit raise,
                           output logic [7:0] rx, output logic oe);
    rx = '0;
    oe = 1'b0;
    cs = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? tx[15-i] : 1'b1;
      wait_clk(HP);
      if (i == 0) oe = miso_oe;
      if (i >= 8 && i < 16) rx = {rx[6:0], miso};
      sclk = 1'b1;
      wait_clk(HP);
      sclk = 1'b0;
    end
    if (raise) begin
      wait_clk(HP);
      cs   = 1'b1;
      mosi = 1'b0;
      wait_clk(2*HP);
    end
  endtask

  task automatic sb_frame(input string name, input logic [15:0] tx, input logic [7:0] exp_rx);
    logic [7:0] rx, got;
    logic       oe;
    int         f0;
    exp_q.push_back(exp_rx);
    f0 = fd_cnt;
    spi_frame(tx, 16, 1'b1, rx, oe);
    got = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({name, "_rx"}, {24'h0, rx}, {24'h0, got});
    check({name, "_fd"}, fd_cnt - f0, 1);
  endtask

  initial begin
    logic [7:0] rx, got;
    logic       oe;
    int         f0;
    v[0]  = '{16'h803C, 16, 8'h00, 8'h3C, 1};
    v[1]  = '{16'h0300, 16, 8'hA5, 8'h3C, 1};
    v[2]  = '{16'h815A, 16, 8'h00, 8'h3C, 1};
    v[3]  = '{16'h0100, 16, 8'h5A, 8'h3C, 1};
    v[4]  = '{16'h0200, 16, 8'h04, 8'h3C, 1};
    v[5]  = '{16'h80FF, 12, 8'h00, 8'h3C, 0};
    v[6]  = '{16'h8577, 16, 8'h00, 8'h3C, 1};
    v[7]  = '{16'h0500, 16, 8'h00, 8'h3C, 1};
    v[8]  = '{16'h0200, 20, 8'h07, 8'h3C, 1};
    v[9]  = '{16'h8001, 16, 8'h3C, 8'h01, 1};
    v[10] = '{16'h0000, 16, 8'h01, 8'h01, 1};
    v[11] = '{16'h8203, 16, 8'h0A, 8'h01, 1};
    v[12] = '{16'h0200, 16, 8'h0B, 8'h01, 1};
    v[13] = '{16'h8344, 16, 8'hA5, 8'h01, 1};
    v[14] = '{16'h0300, 16, 8'hA5, 8'h01, 1};

    wait_clk(3);
    check("rst_led", {24'h0, led}, 32'h0);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_oe", {31'h0, miso_oe}, 32'h0);
    check("rst_fd", {31'h0, frame_done}, 32'h0);
    rst_n = 1'b1;
    wait_clk(4);
    check("idle_oe", {31'h0, miso_oe}, 32'h0);

    for (int k = 0; k < 15; k++) begin
      if (v[k].nbits >= 16) exp_q.push_back(v[k].rx);
      f0 = fd_cnt;
      spi_frame(v[k].tx, v[k].nbits, 1'b1, rx, oe);
      if (v[k].nbits >= 16) begin
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check($sformatf("vec%0d_rx", k), {24'h0, rx}, {24'h0, got});
      end
      check($sformatf("vec%0d_led", k), {24'h0, led}, {24'h0, v[k].led});
      check($sformatf("vec%0d_fd", k), fd_cnt - f0, v[k].fd);
      check($sformatf("vec%0d_oe", k), {31'h0, oe}, 32'h1);
      check($sformatf("vec%0d_oe_idle", k), {31'h0, miso_oe}, 32'h0);
    end

    f0 = fd_cnt;
    spi_frame(16'h80AA, 12, 1'b0, rx, oe);
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_led", {24'h0, led}, 32'h0);
    check("mid_rst_miso", {31'h0, miso}, 32'h0);
    check("mid_rst_oe", {31'h0, miso_oe}, 32'h0);
    check("mid_rst_fd", {31'h0, frame_done}, 32'h0);
    wait_clk(2);
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(6);
    check("mid_rst_nofd", fd_cnt - f0, 0);

    sb_frame("post_rst_id", 16'h0300, 8'hA5);
    sb_frame("post_rst_wr", 16'h8055, 8'h00);
    check("post_rst_led", {24'h0, led}, 32'h55);
    for (int k = 0; k < 254; k++) sb_frame($sformatf("wrap%0d", k), 16'h0200, 8'((k + 2) & 8'hFF));
    sb_frame("wrap_zero", 16'h0200, 8'h00);
    sb_frame("wrap_one", 16'h0200, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
